bin2bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It has ready/valid handshakes on both sides, overflow detection and a leading-zero blanking mask. It sits between arithmetic or counter logic and the seven-segment and VGA text renderers, and supersedes the fixed 14-bit/4-digit converter.

---
 rtl/bin2bcd_seq.sv | 110 +++++++++++
 tb/tb_bin2bcd_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
// Optional two's-complement input with sign output when BIN2BCD_SIGNED_EN is defined.
module bin2bcd_seq #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     lz_mask,
    output logic                  overflow
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                  sign
`endif
);

    localparam int CW = $clog2(IN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state;
    logic [IN_W-1:0]     shreg;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] adj;
    logic [IN_W-1:0]     load_val;
    logic                upper_zero;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

`ifdef BIN2BCD_SIGNED_EN
    // Negating the most negative value wraps onto itself, which is the correct unsigned magnitude.
    assign load_val = in_data[IN_W-1] ? ((~in_data) + IN_W'(1)) : in_data;
`else
    assign load_val = in_data;
`endif

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd4) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (bcd[4*i +: 4] == 4'd0);
            lz_mask[i] = upper_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            shreg    <= '0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg    <= load_val;
                        bcd      <= '0;
                        overflow <= 1'b0;
                        cnt      <= '0;
`ifdef BIN2BCD_SIGNED_EN
                        sign     <= in_data[IN_W-1];
`endif
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A bit carried out of the top digit means the value no longer fits.
                    bcd   <= {adj[4*DIGITS-2:0], shreg[IN_W-1]};
                    if (adj[4*DIGITS-1]) begin
                        overflow <= 1'b1;
                    end
                    shreg <= shreg << 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(IN_W - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed-vector bench for bin2bcd_seq with a transaction-level reference model
module tb_bin2bcd_seq;

    localparam int IN_W   = 14;
    localparam int DIGITS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       bcd;
    logic [3:0]        lz_mask;
    logic              overflow;
`ifdef BIN2BCD_SIGNED_EN
    logic              sign;
`endif

    bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .bcd(bcd), .lz_mask(lz_mask), .overflow(overflow)
`ifdef BIN2BCD_SIGNED_EN
        , .sign(sign)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic on the integer value, not digit manipulation.
    function automatic int mag_of(input logic [IN_W-1:0] d);
`ifdef BIN2BCD_SIGNED_EN
        if (d[IN_W-1]) return (1 << IN_W) - int'(d);
`endif
        return int'(d);
    endfunction

    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        int m;
        m = v % 10000;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_lz(input int v);
        logic [3:0] r;
        int m;
        int p;
        m = v % 10000;
        p = 1;
        r = '0;
        for (int i = 1; i < DIGITS; i++) begin
            p = p * 10;
            r[i] = (m < p);
        end
        return r;
    endfunction

    // Model of the handshake timing: idle, busy for IN_W edges, then done until consumed.
    bit              m_idle = 1'b1;
    bit              m_done = 1'b0;
    int              m_left = 0;
    logic [15:0]     e_bcd;
    logic [3:0]      e_lz;
    logic            e_ovf;
    logic            e_sign;
    logic            p_valid = 1'b0;
    logic            p_oready = 1'b0;
    logic [IN_W-1:0] p_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            m_idle = 1'b1; m_done = 1'b0; m_left = 0;
            p_valid = 1'b0; p_oready = 1'b0;
            check("reset_in_ready", 32'(in_ready), 32'd1);
            check("reset_out_valid", 32'(out_valid), 32'd0);
            check("reset_bcd", 32'(bcd), 32'd0);
            check("reset_lz", 32'(lz_mask), 32'b1110);
            check("reset_ovf", 32'(overflow), 32'd0);
        end else begin
            if (m_idle) begin
                if (p_valid) begin
                    m_idle = 1'b0;
                    m_left = IN_W;
                    e_bcd  = model_bcd(mag_of(p_data));
                    e_lz   = model_lz(mag_of(p_data));
                    e_ovf  = (mag_of(p_data) > 9999);
                    e_sign = p_data[IN_W-1];
                end
            end else if (!m_done) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (p_oready) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end
            check("mon_in_ready", 32'(in_ready), 32'(m_idle));
            check("mon_out_valid", 32'(out_valid), 32'(m_done));
            if (m_done) begin
                check("mon_bcd", 32'(bcd), 32'(e_bcd));
                check("mon_lz", 32'(lz_mask), 32'(e_lz));
                check("mon_ovf", 32'(overflow), 32'(e_ovf));
`ifdef BIN2BCD_SIGNED_EN
                check("mon_sign", 32'(sign), 32'(e_sign));
`endif
            end
            p_valid  = in_valid;
            p_oready = out_ready;
            p_data   = in_data;
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) check("timeout_in_ready", 32'd0, 32'd1);
    endtask

    task automatic wait_out(output int edges);
        edges = 1;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1; edges++;
        end
        if (!out_valid) check("timeout_out_valid", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [IN_W-1:0] v, input logic [15:0] x_bcd, input logic x_ovf,
                       input logic [3:0] x_lz, input logic x_sign);
        int e;
        wait_ready();
        in_data = v; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(e);
        check("latency_edges", 32'(e), 32'(IN_W + 1));
        check("lit_bcd", 32'(bcd), 32'(x_bcd));
        check("lit_ovf", 32'(overflow), 32'(x_ovf));
        check("lit_lz", 32'(lz_mask), 32'(x_lz));
`ifdef BIN2BCD_SIGNED_EN
        check("lit_sign", 32'(sign), 32'(x_sign));
`else
        if (x_sign) check("unsigned_sign_request", 32'd1, 32'd0);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int e;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("init_in_ready", 32'(in_ready), 32'd1);
        check("init_lz", 32'(lz_mask), 32'b1110);

`ifndef BIN2BCD_SIGNED_EN
        run(14'd9999, 16'h9999, 1'b0, 4'b0000, 1'b0);
        run(14'd10000, 16'h0000, 1'b1, 4'b1110, 1'b0);
        run(14'd42, 16'h0042, 1'b0, 4'b1100, 1'b0);
        run(14'd16383, 16'h6383, 1'b1, 4'b0000, 1'b0);
        run(14'd807, 16'h0807, 1'b0, 4'b1000, 1'b0);
`endif

        // Back-to-back: 0 then 1 with out_ready held high and in_valid left asserted.
        wait_ready();
        out_ready = 1'b1; in_valid = 1'b1; in_data = '0;
        @(posedge clk); #1;
        in_data = 14'd1;
        wait_out(e);
        check("b2b_first_bcd", 32'(bcd), 32'h0000);
        check("b2b_first_lz", 32'(lz_mask), 32'b1110);
        @(posedge clk); #1;
        check("b2b_taken_in_ready", 32'(in_ready), 32'd1);
        check("b2b_taken_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("b2b_second_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_out(e);
        check("b2b_second_bcd", 32'(bcd), 32'h0001);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Hold the 1234 result for 50 cycles while a new request is offered.
        wait_ready();
        in_data = 14'd1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(e);
        in_valid = 1'b1; in_data = 14'd77;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_bcd", 32'(bcd), 32'h1234);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a conversion discards it.
        wait_ready();
        in_data = 14'd9999; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_bcd", 32'(bcd), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("after_reset_no_valid", 32'(out_valid), 32'd0);
        end
        run(14'd5, 16'h0005, 1'b0, 4'b1110, 1'b0);

`ifdef BIN2BCD_SIGNED_EN
        run(14'(-1234), 16'h1234, 1'b0, 4'b0000, 1'b1);
        run(14'h2000, 16'h8192, 1'b0, 4'b0000, 1'b1);
        run(14'd42, 16'h0042, 1'b0, 4'b1100, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
